vec_rf_port_arbiter: RTL and testbench

VEC_RF_PORT_ARBITER -- requirements
Module: vec_rf_port_arbiter

---
 rtl/vec_rf_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_vec_rf_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_rf_port_arbiter.sv
// -----------------------------------------------------------------------------
// vec_rf_port_arbiter
//
// Purpose:
//   Shares PORTS vector register-file ports among NUM_REQ requesters. Each
//   cycle up to PORTS requests are granted, scanning requesters in round-robin
//   order from rr_ptr. The k-th granted requester drives regfile port k
//   combinationally in the grant cycle. Same-cycle hazards are resolved by
//   the arbiter:
//     - write/write to one address: only the earlier (round-robin order) write
//       is granted, the later one waits.
//     - read/write to one address: the later one waits, unless the build
//       defines VRF_BYPASS_EN, in which case both are granted and the read
//       returns the write data instead of regfile read data.
//   Read data comes back from the regfile one cycle after the grant. A
//   per-port tag {valid, requester id} is registered at the grant and steers
//   that data to the requester's response slice.
//
// Configuration macro:
//   VRF_BYPASS_EN  enable same-cycle read/write forwarding (default: off).
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]            per-requester request
//   req_rw     in   [NUM_REQ]            1 = write, 0 = read
//   req_addr   in   [NUM_REQ*ADDR_WIDTH] address, requester i at slice i
//   req_wdata  in   [NUM_REQ*VLEN_B]     write data
//   req_ready  out  [NUM_REQ]            grant; transfer on valid && ready
//   rsp_valid  out  [NUM_REQ]            read data valid, one-cycle pulse
//   rsp_rdata  out  [NUM_REQ*VLEN_B]     read data, holds when not valid
//   rf_en      out  [PORTS]              regfile port enable
//   rf_rw      out  [PORTS]              regfile port direction, 1 = write
//   rf_addr    out  [PORTS*ADDR_WIDTH]   regfile port address
//   rf_wdata   out  [PORTS*VLEN_B]       regfile port write data
//   rf_rdata   in   [PORTS*VLEN_B]       regfile read data, one cycle later
//
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high; req_ready never rises without req_valid, and a
// requester may drop req_valid at any time while not granted.
// -----------------------------------------------------------------------------
module vec_rf_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int PORTS      = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int VLEN_B     = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*VLEN_B-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [NUM_REQ*VLEN_B-1:0]    rsp_rdata,
    output logic [PORTS-1:0]             rf_en,
    output logic [PORTS-1:0]             rf_rw,
    output logic [PORTS*ADDR_WIDTH-1:0]  rf_addr,
    output logic [PORTS*VLEN_B-1:0]      rf_wdata,
    input  logic [PORTS*VLEN_B-1:0]      rf_rdata
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Round-robin pointer: first requester considered in the next scan.
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] next_ptr;

    // Combinational grant results.
    logic [NUM_REQ-1:0]          grant;
    logic [PORTS-1:0][ID_W-1:0]  port_id;
    logic [ID_W-1:0]             last_id;
    logic                        any_grant;

    // Response tags, one stage deep, one per port.
    logic [PORTS-1:0]            tag_valid;
    logic [PORTS-1:0][ID_W-1:0]  tag_id;

    // Last delivered read data per requester (held while rsp_valid is low).
    logic [NUM_REQ*VLEN_B-1:0]   rsp_hold;

    // -------------------------------------------------------------------------
    // Grant scan. Requesters are visited in round-robin order; every index is
    // resolved through constant loops and equality compares so no selects use
    // a data-dependent index.
    // -------------------------------------------------------------------------
    always_comb begin
        int                               slot;
        int                               idx;
        logic                             c_valid;
        logic                             c_rw;
        logic [ADDR_WIDTH-1:0]            c_addr;
        logic [VLEN_B-1:0]                c_wdata;
        logic                             blocked;
        logic [PORTS-1:0][ADDR_WIDTH-1:0] s_addr;
        logic [PORTS-1:0]                 s_rw;

        grant     = '0;
        port_id   = '0;
        last_id   = rr_ptr;
        any_grant = 1'b0;
        rf_en     = '0;
        rf_rw     = '0;
        rf_addr   = '0;
        rf_wdata  = '0;
        slot      = 0;
        idx       = 0;
        c_valid   = 1'b0;
        c_rw      = 1'b0;
        c_addr    = '0;
        c_wdata   = '0;
        blocked   = 1'b0;
        s_addr    = '0;
        s_rw      = '0;

        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end

            c_valid = 1'b0;
            c_rw    = 1'b0;
            c_addr  = '0;
            c_wdata = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == idx) begin
                    c_valid = req_valid[i];
                    c_rw    = req_rw[i];
                    c_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    c_wdata = req_wdata[i*VLEN_B +: VLEN_B];
                end
            end

            // Hazard check against requests already granted this cycle.
            blocked = 1'b0;
            for (int p = 0; p < PORTS; p++) begin
                if (p < slot && s_addr[p] == c_addr) begin
                    if (s_rw[p] && c_rw) begin
                        blocked = 1'b1;
                    end
`ifndef VRF_BYPASS_EN
                    if (s_rw[p] != c_rw) begin
                        blocked = 1'b1;
                    end
`endif
                end
            end

            if (rst_n && c_valid && !blocked && slot < PORTS) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == idx) begin
                        grant[i] = 1'b1;
                    end
                end
                for (int p = 0; p < PORTS; p++) begin
                    if (p == slot) begin
                        rf_en[p]                              = 1'b1;
                        rf_rw[p]                              = c_rw;
                        rf_addr[p*ADDR_WIDTH +: ADDR_WIDTH]   = c_addr;
                        rf_wdata[p*VLEN_B +: VLEN_B]          = c_wdata;
                        port_id[p]                            = ID_W'(idx);
                        s_addr[p]                             = c_addr;
                        s_rw[p]                               = c_rw;
                    end
                end
                last_id   = ID_W'(idx);
                any_grant = 1'b1;
                slot      = slot + 1;
            end
        end
    end

    assign req_ready = grant;

    // Pointer moves just past the last requester granted this cycle.
    assign next_ptr = (int'(last_id) == NUM_REQ - 1) ? '0 : last_id + ID_W'(1);

`ifdef VRF_BYPASS_EN
    // -------------------------------------------------------------------------
    // Forwarding: a read port whose address matches a write port granted in
    // the same cycle takes that write data instead of the regfile read data.
    // -------------------------------------------------------------------------
    logic [PORTS-1:0]        fwd_hit;
    logic [PORTS*VLEN_B-1:0] fwd_data;
    logic [PORTS-1:0]        tag_fwd;
    logic [PORTS*VLEN_B-1:0] tag_fwd_data;

    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        for (int p = 0; p < PORTS; p++) begin
            for (int q = 0; q < PORTS; q++) begin
                if (rf_en[p] && !rf_rw[p] && rf_en[q] && rf_rw[q] &&
                    rf_addr[p*ADDR_WIDTH +: ADDR_WIDTH] ==
                    rf_addr[q*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    fwd_hit[p]                   = 1'b1;
                    fwd_data[p*VLEN_B +: VLEN_B] = rf_wdata[q*VLEN_B +: VLEN_B];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_fwd      <= '0;
            tag_fwd_data <= '0;
        end else begin
            tag_fwd      <= fwd_hit;
            tag_fwd_data <= fwd_data;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Pointer, response tags and held read data.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            tag_valid <= '0;
            tag_id    <= '0;
            rsp_hold  <= '0;
        end else begin
            if (any_grant) begin
                rr_ptr <= next_ptr;
            end
            for (int p = 0; p < PORTS; p++) begin
                tag_valid[p] <= rf_en[p] && !rf_rw[p];
                tag_id[p]    <= port_id[p];
            end
            rsp_hold <= rsp_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // Response steering: a valid tag routes its port's returning data to the
    // tagged requester; other slices present their held value.
    // -------------------------------------------------------------------------
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = rsp_hold;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (tag_valid[p] && tag_id[p] == ID_W'(i)) begin
                    rsp_valid[i] = 1'b1;
`ifdef VRF_BYPASS_EN
                    if (tag_fwd[p]) begin
                        rsp_rdata[i*VLEN_B +: VLEN_B] = tag_fwd_data[p*VLEN_B +: VLEN_B];
                    end else begin
                        rsp_rdata[i*VLEN_B +: VLEN_B] = rf_rdata[p*VLEN_B +: VLEN_B];
                    end
`else
                    rsp_rdata[i*VLEN_B +: VLEN_B] = rf_rdata[p*VLEN_B +: VLEN_B];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_rf_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vec_rf_port_arbiter
//
// Bench for vec_rf_port_arbiter with a simple one-cycle-latency regfile
// attached to the rf_* port. A behavioural model predicts grants, regfile
// port drive and read responses from the arbitration rules; every cycle the
// DUT outputs are compared against it, with directed scenarios pinned by
// literal expectations followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_vec_rf_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int PORTS   = 2;
    localparam int AW      = 5;
    localparam int VB      = 128;
    localparam int DEPTH   = 1 << AW;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]    req_valid, req_rw, req_ready, rsp_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*VB-1:0] req_wdata, rsp_rdata;
    logic [PORTS-1:0]      rf_en, rf_rw;
    logic [PORTS*AW-1:0]   rf_addr;
    logic [PORTS*VB-1:0]   rf_wdata, rf_rdata;

    vec_rf_port_arbiter #(
        .NUM_REQ(NUM_REQ), .PORTS(PORTS), .ADDR_WIDTH(AW), .VLEN_B(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rf_en(rf_en), .rf_rw(rf_rw), .rf_addr(rf_addr),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // Regfile attached to the DUT ports: registered read, cleared in reset.
    logic [VB-1:0] rf_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) rf_mem[a] <= '0;
            rf_rdata <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (rf_en[p]) begin
                    if (rf_rw[p]) rf_mem[rf_addr[p*AW +: AW]] <= rf_wdata[p*VB +: VB];
                    else          rf_rdata[p*VB +: VB] <= rf_mem[rf_addr[p*AW +: AW]];
                end
            end
        end
    end

    // Scoreboard counters
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [NUM_REQ*VB-1:0] act,
                       input logic [NUM_REQ*VB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model state
    int            m_ptr;
    logic [VB-1:0] m_mem    [0:DEPTH-1];
    bit            m_pend   [NUM_REQ];
    logic [VB-1:0] m_pend_d [NUM_REQ];
    logic [VB-1:0] m_hold   [NUM_REQ];
    bit            n_pend   [NUM_REQ];
    logic [VB-1:0] n_pend_d [NUM_REQ];
    int            g_q[$];
    int            n_last;
    bit            n_any;

    logic [NUM_REQ-1:0]    e_ready, e_rsp_v;
    logic [NUM_REQ*VB-1:0] e_rsp_d;
    logic [PORTS-1:0]      e_en, e_rw;
    logic [PORTS*AW-1:0]   e_addr;
    logic [PORTS*VB-1:0]   e_wdata;

    function automatic logic [AW-1:0] a_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    // Let inputs settle, predict this cycle's outputs and compare.
    task automatic settle();
        int  i, g, s;
        bit  ok;
        #1;
        if (!rst_n) begin
            m_ptr = 0;
            for (int r = 0; r < NUM_REQ; r++) begin
                m_pend[r] = 0;
                m_hold[r] = '0;
            end
        end
        e_ready = '0; e_en = '0; e_rw = '0; e_addr = '0; e_wdata = '0;
        g_q.delete();
        n_any = 0;
        n_last = 0;
        for (int r = 0; r < NUM_REQ; r++) begin
            n_pend[r]   = 0;
            n_pend_d[r] = '0;
        end
        if (rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                i = (m_ptr + k) % NUM_REQ;
                if (!req_valid[i] || g_q.size() >= PORTS) continue;
                ok = 1;
                foreach (g_q[j]) begin
                    g = g_q[j];
                    if (a_of(g) == a_of(i)) begin
                        if (req_rw[g] && req_rw[i]) ok = 0;
`ifndef VRF_BYPASS_EN
                        if (req_rw[g] != req_rw[i]) ok = 0;
`endif
                    end
                end
                if (ok) begin
                    s = g_q.size();
                    e_ready[i]           = 1'b1;
                    e_en[s]              = 1'b1;
                    e_rw[s]              = req_rw[i];
                    e_addr[s*AW +: AW]   = a_of(i);
                    e_wdata[s*VB +: VB]  = req_wdata[i*VB +: VB];
                    g_q.push_back(i);
                    n_last = i;
                    n_any  = 1;
                end
            end
        end
        // Reads granted now answer next cycle with pre-write contents
        // (or the same-cycle write data when forwarding is built in).
        foreach (g_q[j]) begin
            g = g_q[j];
            if (!req_rw[g]) begin
                n_pend[g]   = 1;
                n_pend_d[g] = m_mem[a_of(g)];
`ifdef VRF_BYPASS_EN
                foreach (g_q[q]) begin
                    if (req_rw[g_q[q]] && a_of(g_q[q]) == a_of(g))
                        n_pend_d[g] = req_wdata[g_q[q]*VB +: VB];
                end
`endif
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            e_rsp_v[r]         = m_pend[r];
            e_rsp_d[r*VB +: VB] = m_pend[r] ? m_pend_d[r] : m_hold[r];
        end
        chk("req_ready", req_ready, e_ready);
        chk("rf_en",     rf_en,     e_en);
        chk("rf_rw",     rf_rw,     e_rw);
        chk("rf_addr",   rf_addr,   e_addr);
        chk("rf_wdata",  rf_wdata,  e_wdata);
        chk("rsp_valid", rsp_valid, e_rsp_v);
        chk("rsp_rdata", rsp_rdata, e_rsp_d);
    endtask

    // Clock edge: commit model state, then return at the falling edge.
    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                m_pend[r] = 0;
                m_hold[r] = '0;
            end
            m_ptr = 0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                m_hold[r]   = e_rsp_d[r*VB +: VB];
                m_pend[r]   = n_pend[r];
                m_pend_d[r] = n_pend_d[r];
            end
            foreach (g_q[j]) begin
                if (req_rw[g_q[j]]) m_mem[a_of(g_q[j])] = req_wdata[g_q[j]*VB +: VB];
            end
            if (n_any) m_ptr = (n_last + 1) % NUM_REQ;
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    // Driver tasks
    task automatic clr();
        req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic rw, input int a, input logic [VB-1:0] d);
        req_valid[i]        = 1'b1;
        req_rw[i]           = rw;
        req_addr[i*AW +: AW] = AW'(a);
        req_wdata[i*VB +: VB] = d;
    endtask

    logic [VB-1:0] v3, d1, d2, vabc, v55;

    initial begin
        v3   = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        d1   = {32'hD1D1_0001, 32'h0, 32'h0, 32'hD1D1_0002};
        d2   = {32'hD2D2_0001, 32'h0, 32'h0, 32'hD2D2_0002};
        vabc = 128'hABCDEF0123456789;
        v55  = 128'h55;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;

        // Reset with all requesters reading
        rst_n = 1'b0;
        clr();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 3, '0);
        settle();
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_rf_en", rf_en, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        advance();
        step();

        // Release: requesters 0 and 1 go first
        rst_n = 1'b1;
        settle();
        chk("first_grant", req_ready, 4'b0011);
        chk("model_first_grant", e_ready, 4'b0011);
        advance();
        clr();
        step();

        // Requester 3 writes addr 3, pointer wraps to 0
        set_req(3, 1'b1, 3, v3);
        step();
        clr();
        step();

        // Round-robin reads of addr 3
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 3, '0);
        settle();
        chk("rr_grant_a", req_ready, 4'b0011);
        advance();
        settle();
        chk("rr_grant_b", req_ready, 4'b1100);
        chk("rr_rsp_a", rsp_valid, 4'b0011);
        chk("rr_data_0", rsp_rdata[0*VB +: VB], v3);
        chk("rr_data_1", rsp_rdata[1*VB +: VB], v3);
        advance();
        settle();
        chk("rr_grant_c", req_ready, 4'b0011);
        chk("rr_rsp_b", rsp_valid, 4'b1100);
        chk("rr_data_3", rsp_rdata[3*VB +: VB], v3);
        advance();
        clr();
        settle();
        chk("rr_rsp_c", rsp_valid, 4'b0011);
        advance();

        // Write then read on the next cycle
        set_req(0, 1'b1, 0, vabc);
        settle();
        chk("wr_grant", req_ready, 4'b0001);
        advance();
        clr();
        set_req(2, 1'b0, 0, '0);
        settle();
        chk("rd_grant", req_ready, 4'b0100);
        advance();
        clr();
        settle();
        chk("wr_rd_rsp", rsp_valid, 4'b0100);
        chk("wr_rd_data", rsp_rdata[2*VB +: VB], vabc);
        advance();

        // Move pointer to 1, then two writes to addr 7
        set_req(0, 1'b0, 1, '0);
        step();
        clr();
        set_req(1, 1'b1, 7, d1);
        set_req(2, 1'b1, 7, d2);
        settle();
        chk("waw_first", req_ready, 4'b0010);
        advance();
        req_valid[1] = 1'b0;
        settle();
        chk("waw_second", req_ready, 4'b0100);
        advance();
        clr();
        set_req(3, 1'b0, 7, '0);
        settle();
        chk("waw_rd_grant", req_ready, 4'b1000);
        advance();
        clr();
        settle();
        chk("waw_rsp", rsp_valid, 4'b1000);
        chk("waw_final", rsp_rdata[3*VB +: VB], d2);
        advance();

        // Same-cycle write/read on addr 5
        set_req(0, 1'b1, 5, v55);
        set_req(1, 1'b0, 5, '0);
        settle();
`ifdef VRF_BYPASS_EN
        chk("raw_both", req_ready, 4'b0011);
        advance();
        clr();
`else
        chk("raw_write_only", req_ready, 4'b0001);
        advance();
        req_valid[0] = 1'b0;
        settle();
        chk("raw_read_later", req_ready, 4'b0010);
        advance();
        clr();
`endif
        settle();
        chk("raw_rsp", rsp_valid, 4'b0010);
        chk("raw_data", rsp_rdata[1*VB +: VB], v55);
        advance();

        // Reset in the cycle after a read grant drops the response
        set_req(2, 1'b0, 7, '0);
        settle();
        chk("mid_rd_grant", req_ready, 4'b0100);
        advance();
        clr();
        rst_n = 1'b0;
        settle();
        chk("mid_rst_rsp", rsp_valid, 4'b0000);
        advance();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("post_rst_rsp", rsp_valid, 4'b0000);
            advance();
        end

        // Randomized traffic on a narrow address range to provoke hazards
        for (int c = 0; c < 800; c++) begin
            rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            clr();
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 3) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                            {$urandom, $urandom, $urandom, $urandom});
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
